// File: rtl/beat_scheduler_pkg.sv
// Shared types and constants for the beat scheduler and its BPM lookup.
package beat_sched_pkg;

  localparam int SCALER_W    = 20;
  localparam int BPM_W       = 8;
  localparam int DEFAULT_BPM = 120;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } state_t;

  // Elaboration-time only: builds LUT contents and reset constants.
  function automatic logic [SCALER_W-1:0] bpm_to_scaler(input int bpm);
    if (bpm == 0) return '1;
    return SCALER_W'((1000000 + bpm / 2) / bpm);
  endfunction

endpackage

// File: rtl/beat_scheduler_lut.sv
// BPM to timebase-tick count lookup: round(1e6/bpm), 20'hFFFFF for bpm=0.
module BPM_lut
  import beat_sched_pkg::*;
(
  input  logic [BPM_W-1:0]    bpm,
  output logic [SCALER_W-1:0] scaler
);

  logic [SCALER_W-1:0] rom [0:(1<<BPM_W)-1];

  for (genvar g = 0; g < (1 << BPM_W); g++) begin : g_rom
    assign rom[g] = bpm_to_scaler(g);
  end

  assign scaler = rom[bpm];

endmodule

// File: rtl/beat_scheduler.sv
// Beat generator with beat-aligned tempo changes; period = PRESCALE * LUT(bpm).
//   state    | meaning
//   ST_IDLE  | counters and step held at zero, pending tempo applied at once
//   ST_START | first beat of a run (step 0), counters freshly loaded
//   ST_RUN   | counting; beat and pending tempo applied at each boundary
module beat_scheduler
  import beat_sched_pkg::*;
#(
  parameter int PRESCALE    = 3000,
  parameter int DEFAULT_BPM = beat_sched_pkg::DEFAULT_BPM,
  parameter int STEPS       = 16,
  localparam int STEP_W     = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              bpm_req,
  input  logic [BPM_W-1:0]  bpm_val,
  output logic              bpm_ack,
  output logic              bpm_err,
  output logic              pending,
  output logic [BPM_W-1:0]  active_bpm,
  output logic              beat,
  output logic [STEP_W-1:0] step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [SCALER_W-1:0] SCALER_RST = bpm_to_scaler(DEFAULT_BPM);
  localparam logic [BPM_W-1:0]    BPM_RST    = BPM_W'(DEFAULT_BPM);

  state_t              state, state_nx;
  logic [PW-1:0]       pre_cnt;
  logic [SCALER_W-1:0] tick_cnt;
  logic [SCALER_W-1:0] scaler_q;
  logic [SCALER_W-1:0] lut_scaler;
  logic [BPM_W-1:0]    req_bpm;
  logic                terminal;
  logic                boundary;
  logic                apply;

  // active_bpm is never zero, so the LUT's 0 entry is never addressed.
  BPM_lut u_lut (
    .bpm    (active_bpm),
    .scaler (lut_scaler)
  );

  assign terminal = (pre_cnt == PRE_LAST) && (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    boundary = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nx = ST_START;
      end
      ST_START, ST_RUN: begin
        if (!run) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RUN;
          boundary = terminal;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    apply = pending && ((state == ST_IDLE) || boundary);
  end

  // Reload uses the already-registered scaler, so a tempo applied at a
  // boundary only shapes the period that starts at the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
      step     <= '0;
      beat     <= 1'b0;
      scaler_q <= SCALER_RST;
    end else begin
      beat     <= 1'b0;
      scaler_q <= lut_scaler;
      if (state_nx == ST_IDLE) begin
        pre_cnt  <= '0;
        tick_cnt <= '0;
        step     <= '0;
      end else if ((state == ST_IDLE) || boundary) begin
        beat     <= 1'b1;
        pre_cnt  <= '0;
        tick_cnt <= scaler_q - SCALER_W'(1);
        step     <= (state == ST_IDLE) ? '0 : step + STEP_W'(1);
      end else if (pre_cnt == PRE_LAST) begin
        pre_cnt  <= '0;
        tick_cnt <= tick_cnt - SCALER_W'(1);
      end else begin
        pre_cnt  <= pre_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bpm <= BPM_RST;
      req_bpm    <= '0;
      pending    <= 1'b0;
      bpm_ack    <= 1'b0;
      bpm_err    <= 1'b0;
    end else begin
      bpm_ack <= 1'b0;
      bpm_err <= 1'b0;
      if (apply) begin
        active_bpm <= req_bpm;
        pending    <= 1'b0;
        bpm_ack    <= 1'b1;
      end else if (bpm_req && !pending) begin
        if (bpm_val == '0) begin
          bpm_ack <= 1'b1;
          bpm_err <= 1'b1;
        end else begin
          req_bpm <= bpm_val;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed bench for beat_scheduler with PRESCALE=1 so periods equal LUT values.
module tb_beat_scheduler;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       bpm_req;
  logic [7:0] bpm_val;
  logic       bpm_ack;
  logic       bpm_err;
  logic       pending;
  logic [7:0] active_bpm;
  logic       beat;
  logic [3:0] step;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt  = 0;

  beat_scheduler #(
    .PRESCALE    (1),
    .DEFAULT_BPM (120),
    .STEPS       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bpm_req    (bpm_req),
    .bpm_val    (bpm_val),
    .bpm_ack    (bpm_ack),
    .bpm_err    (bpm_err),
    .pending    (pending),
    .active_bpm (active_bpm),
    .beat       (beat),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All sampling happens on the falling edge, away from the active edge.
  task automatic nclk();
    @(negedge clk);
    cyc++;
    if (bpm_ack) ack_cnt++;
  endtask

  task automatic wait_beat(input int limit, output int n);
    n = 0;
    do begin
      nclk();
      n++;
    end while (!beat && n < limit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; bpm_req = 1'b0; bpm_val = 8'd0;
    repeat (3) nclk();
    checks++; if (active_bpm !== 8'd120) begin failures++; $display("FAIL reset_active_bpm got=%0d exp=120", active_bpm); end
    checks++; if (beat !== 1'b0) begin failures++; $display("FAIL reset_beat got=%b exp=0", beat); end
    checks++; if (bpm_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bpm_ack); end
    checks++; if (bpm_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bpm_err); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (step !== 4'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    rst_n = 1'b1;
    repeat (3) nclk();
    checks++; if (beat !== 1'b0) begin failures++; $display("FAIL idle_no_beat got=%b exp=0", beat); end
  endtask

  task automatic test_timing();
    int n;
    run = 1'b1;
    nclk();
    checks++; if (beat !== 1'b1) begin failures++; $display("FAIL start_beat got=%b exp=1", beat); end
    checks++; if (step !== 4'd0) begin failures++; $display("FAIL start_step got=%0d exp=0", step); end
    wait_beat(8400, n);
    checks++; if (n !== 8333) begin failures++; $display("FAIL period_120 got=%0d exp=8333", n); end
    checks++; if (step !== 4'd1) begin failures++; $display("FAIL step_second_beat got=%0d exp=1", step); end
    run = 1'b0;
    nclk();
    checks++; if (beat !== 1'b0) begin failures++; $display("FAIL stop_beat got=%b exp=0", beat); end
    checks++; if (step !== 4'd0) begin failures++; $display("FAIL stop_step got=%0d exp=0", step); end
  endtask

  task automatic test_beat_aligned_change();
    int n;
    bpm_req = 1'b1; bpm_val = 8'd250;
    nclk();
    bpm_req = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL idle_req_pending got=%b exp=1", pending); end
    nclk();
    checks++; if (bpm_ack !== 1'b1) begin failures++; $display("FAIL idle_apply_ack got=%b exp=1", bpm_ack); end
    checks++; if (active_bpm !== 8'd250) begin failures++; $display("FAIL idle_apply_bpm got=%0d exp=250", active_bpm); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL idle_apply_pending got=%b exp=0", pending); end
    nclk();
    run = 1'b1;
    nclk();
    checks++; if (beat !== 1'b1) begin failures++; $display("FAIL start_250_beat got=%b exp=1", beat); end
    repeat (10) nclk();
    bpm_req = 1'b1; bpm_val = 8'd125;
    nclk();
    bpm_req = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL midbeat_pending got=%b exp=1", pending); end
    checks++; if (active_bpm !== 8'd250) begin failures++; $display("FAIL midbeat_bpm got=%0d exp=250", active_bpm); end
    checks++; if (bpm_ack !== 1'b0) begin failures++; $display("FAIL midbeat_ack got=%b exp=0", bpm_ack); end
    wait_beat(4050, n);
    checks++; if (n !== 3989) begin failures++; $display("FAIL change_period_inflight got=%0d exp=3989", n); end
    checks++; if (bpm_ack !== 1'b1) begin failures++; $display("FAIL boundary_ack got=%b exp=1", bpm_ack); end
    checks++; if (active_bpm !== 8'd125) begin failures++; $display("FAIL boundary_bpm got=%0d exp=125", active_bpm); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL boundary_pending got=%b exp=0", pending); end
    wait_beat(4050, n);
    checks++; if (n !== 4000) begin failures++; $display("FAIL period_after_apply got=%0d exp=4000", n); end
    wait_beat(8050, n);
    checks++; if (n !== 8000) begin failures++; $display("FAIL period_125 got=%0d exp=8000", n); end
    run = 1'b0;
    nclk();
  endtask

  task automatic test_wrap_and_requests();
    int n;
    int ack0;
    int ack16;
    bpm_req = 1'b1; bpm_val = 8'd255;
    nclk();
    bpm_req = 1'b0;
    nclk();
    checks++; if (active_bpm !== 8'd255) begin failures++; $display("FAIL set_255 got=%0d exp=255", active_bpm); end
    nclk();
    run = 1'b1;
    nclk();
    checks++; if (beat !== 1'b1 || step !== 4'd0) begin failures++; $display("FAIL wrap_first_beat got beat=%b step=%0d exp beat=1 step=0", beat, step); end
    ack0  = ack_cnt;
    ack16 = ack_cnt;
    for (int b = 2; b <= 17; b++) begin
      n = 0;
      if (b == 17) ack16 = ack_cnt;
      do begin
        if (b == 3 && n == 100)   begin bpm_req = 1'b1; bpm_val = 8'd0;   end
        if (b == 5 && n == 3921)  begin bpm_req = 1'b1; bpm_val = 8'd255; end
        if (b == 17 && n == 100)  begin bpm_req = 1'b1; bpm_val = 8'd100; end
        if (b == 17 && n == 200)  begin bpm_req = 1'b1; bpm_val = 8'd200; end
        nclk();
        n++;
        bpm_req = 1'b0;
        if (b == 3 && n == 101) begin
          checks++; if (bpm_ack !== 1'b1 || bpm_err !== 1'b1) begin failures++; $display("FAIL zero_req_ack_err got ack=%b err=%b exp 1 1", bpm_ack, bpm_err); end
          checks++; if (active_bpm !== 8'd255 || pending !== 1'b0) begin failures++; $display("FAIL zero_req_state got bpm=%0d pending=%b exp 255 0", active_bpm, pending); end
        end
        if (b == 17 && n == 101) begin
          checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bp_pending got=%b exp=1", pending); end
        end
      end while (!beat && n < 4000);
      checks++; if (n !== 3922) begin failures++; $display("FAIL period_255 beat=%0d got=%0d exp=3922", b, n); end
      checks++; if (step !== 4'((b - 1) % 16)) begin failures++; $display("FAIL step beat=%0d got=%0d exp=%0d", b, step, (b - 1) % 16); end
      if (b == 5) begin
        checks++; if (pending !== 1'b1 || bpm_ack !== 1'b0) begin failures++; $display("FAIL same_cycle_req got pending=%b ack=%b exp 1 0", pending, bpm_ack); end
      end
      if (b == 6) begin
        checks++; if (bpm_ack !== 1'b1 || bpm_err !== 1'b0) begin failures++; $display("FAIL equal_req_ack got ack=%b err=%b exp 1 0", bpm_ack, bpm_err); end
        checks++; if (active_bpm !== 8'd255 || pending !== 1'b0) begin failures++; $display("FAIL equal_req_state got bpm=%0d pending=%b exp 255 0", active_bpm, pending); end
      end
      if (b == 17) begin
        checks++; if (bpm_ack !== 1'b1 || active_bpm !== 8'd100) begin failures++; $display("FAIL bp_apply got ack=%b bpm=%0d exp 1 100", bpm_ack, active_bpm); end
        checks++; if (ack_cnt - ack16 !== 1) begin failures++; $display("FAIL bp_ack_count got=%0d exp=1", ack_cnt - ack16); end
      end
    end
    checks++; if (ack_cnt - ack0 !== 3) begin failures++; $display("FAIL run_ack_total got=%0d exp=3", ack_cnt - ack0); end
    run = 1'b0;
    nclk();
    checks++; if (beat !== 1'b0 || step !== 4'd0) begin failures++; $display("FAIL wrap_stop got beat=%b step=%0d exp 0 0", beat, step); end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      nclk();
      if (beat) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL idle_beats got=%0d exp=0", n); end
  endtask

  task automatic test_reset_mid_op();
    int a0;
    run = 1'b1;
    nclk();
    checks++; if (beat !== 1'b1) begin failures++; $display("FAIL rst_test_start got=%b exp=1", beat); end
    repeat (20) nclk();
    bpm_req = 1'b1; bpm_val = 8'd200;
    nclk();
    bpm_req = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rst_test_pending got=%b exp=1", pending); end
    a0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (active_bpm !== 8'd120) begin failures++; $display("FAIL midrst_bpm got=%0d exp=120", active_bpm); end
    checks++; if (pending !== 1'b0 || beat !== 1'b0 || step !== 4'd0) begin failures++; $display("FAIL midrst_outs got pending=%b beat=%b step=%0d exp 0 0 0", pending, beat, step); end
    checks++; if (bpm_ack !== 1'b0 || bpm_err !== 1'b0) begin failures++; $display("FAIL midrst_ack got ack=%b err=%b exp 0 0", bpm_ack, bpm_err); end
    run = 1'b0;
    nclk();
    nclk();
    rst_n = 1'b1;
    repeat (20) nclk();
    checks++; if (ack_cnt !== a0) begin failures++; $display("FAIL post_rst_ack got=%0d exp=%0d", ack_cnt, a0); end
    checks++; if (beat !== 1'b0 || pending !== 1'b0 || active_bpm !== 8'd120) begin failures++; $display("FAIL post_rst_state got beat=%b pending=%b bpm=%0d exp 0 0 120", beat, pending, active_bpm); end
    run = 1'b1;
    nclk();
    checks++; if (beat !== 1'b1 || step !== 4'd0) begin failures++; $display("FAIL post_rst_start got beat=%b step=%0d exp 1 0", beat, step); end
    run = 1'b0;
    nclk();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_beat_aligned_change();
    test_wrap_and_requests();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/beat_scheduler.md
BEAT_SCHEDULER -- requirements
Module: beat_scheduler

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 3000, meaning clk cycles per timebase tick (60 us at 50 MHz).
REQ-002 The block SHALL have parameter DEFAULT_BPM, default 120, meaning the tempo loaded at reset.
REQ-003 The block SHALL have parameter STEPS, default 16, meaning the step-counter modulus, which must be a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port run, input, 1 bit: level; 1 means generate beats.
REQ-007 The block SHALL have port bpm_req, input, 1 bit: a one-cycle tempo-change request.
REQ-008 The block SHALL have port bpm_val, input, 8 bits: the requested BPM, sampled when bpm_req=1.
REQ-009 The block SHALL have port bpm_ack, output, 1 bit: a one-cycle pulse when a request is resolved (applied or rejected).
REQ-010 The block SHALL have port bpm_err, output, 1 bit: a one-cycle pulse, coincident with bpm_ack, when a request is rejected.
REQ-011 The block SHALL have port pending, output, 1 bit: a request is latched and not yet applied.
REQ-012 The block SHALL have port active_bpm, output, 8 bits: the tempo currently in force.
REQ-013 The block SHALL have port beat, output, 1 bit: a one-cycle pulse per beat.
REQ-014 The block SHALL have port step, output, log2(STEPS) bits: the index of the most recent beat.

Function
REQ-015 Period SHALL be obtained from the BPM lookup: scaler = round(1e6/active_bpm), a 20-bit value, registered one cycle after active_bpm changes.
REQ-016 The beat period SHALL be exactly PRESCALE*scaler clk cycles.
REQ-017 The timebase SHALL use a prescale counter (0..PRESCALE-1) and a 20-bit tick down-counter (scaler-1..0).
  - A beat boundary occurs when both counters reach their terminal values in the same cycle.
REQ-018 The FSM SHALL have states IDLE, START and RUN.
REQ-019 In IDLE, counters SHALL be held at zero and step SHALL be 0.
  - run=1 -> START.
REQ-020 START SHALL last one cycle: beat=1, step=0, counters loaded; then -> RUN.
REQ-021 In RUN, each beat boundary SHALL assert beat for one cycle, increment step (wrapping from STEPS-1 to 0), and reload the counters.
REQ-022 run=0 in START or RUN SHALL return the FSM to IDLE on the next edge; no beat is emitted in that cycle.
REQ-023 A bpm_req with bpm_val=0 SHALL produce bpm_ack=1 and bpm_err=1 on the next cycle, with active_bpm unchanged and pending=0.
REQ-024 A bpm_req with nonzero bpm_val while pending=0 SHALL latch the value and set pending=1 on the next cycle.
REQ-025 In IDLE, a pending value SHALL be applied on the following cycle.
REQ-026 In START or RUN, a pending value SHALL be applied only at a beat boundary, so tempo changes are beat-aligned.
  - Apply means: active_bpm updated, bpm_ack pulses, pending clears.
  - The new period takes effect from the beat after the boundary at which it is applied; the beat in progress completes at the old tempo.
REQ-027 A bpm_req while pending=1 SHALL be ignored, with no ack and no latch.
REQ-028 A bpm_req arriving in the same cycle as a beat boundary SHALL be latched and applied at the next boundary.
REQ-029 A request equal to active_bpm SHALL still be acked at its boundary; the period is unchanged.
REQ-030 The block SHALL never send lookup value 0 to the LUT, so the 20'hFFFFF default is unreachable.

Reset
REQ-031 While rst_n=0, the outputs SHALL be:
  - active_bpm = DEFAULT_BPM
  - beat, bpm_ack, bpm_err, pending = 0
  - step = 0
  - FSM = IDLE
  - counters = 0
  - registered scaler = LUT(DEFAULT_BPM)
REQ-032 Assertion of rst_n mid-beat or mid-request SHALL discard the latched request with no ack; the first beat after release requires run=1 through START.

Structure
REQ-033 A shared package beat_sched_pkg SHALL hold the FSM state encoding, SCALER_W=20, BPM_W=8 and the DEFAULT_BPM constant.
REQ-034 The existing BPM_lut module SHALL be instantiated once as the only sub-module; the block contains no divider.

Verification
REQ-035 Timing: PRESCALE=1, reset, then run=1 -> beat in the START cycle with step=0; next beat 8333 cycles later with step=1 (120 BPM).
REQ-036 Beat-aligned change: PRESCALE=1, running at 250 BPM, bpm_req with bpm_val=125 mid-beat -> pending=1; at the next boundary bpm_ack=1 and active_bpm=125; that beat period stays 4000 cycles, later periods are 8000 cycles.
REQ-037 Invalid tempo: bpm_req with bpm_val=0 -> bpm_ack=1 and bpm_err=1 one cycle later; active_bpm unchanged; beat spacing unchanged.
REQ-038 Back-pressure: a second bpm_req (200) while pending holds 100 -> no ack for 200; active_bpm becomes 100 at the boundary.
REQ-039 Wrap and stop: STEPS=16, run through 17 beats -> step goes 15->0 on beat 17; run=0 -> IDLE next cycle, no beat, step=0.
REQ-040 Reset mid-operation: rst_n=0 while pending and in RUN -> all outputs at reset values; active_bpm=120; no bpm_ack after release.
